// File: rtl/uart_pkg.sv
// Shared types and defaults for the UART transmit queue.
// Optional feature macro: UART_TXQ_OVF_CNT_EN (adds a saturating dropped-byte counter).
package uart_pkg;

  localparam int unsigned UART_DATA_W     = 8;
  localparam int unsigned TXQ_DEPTH_DEF   = 16;
  localparam int unsigned TXQ_BUSY_TO_DEF = 64;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LAUNCH    = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } txq_state_t;

endpackage

// File: rtl/uart_tx_queue_if.sv
// Host/transmitter-facing signal bundle of the UART transmit queue.
// With UART_TXQ_OVF_CNT_EN defined the bundle also carries ovf_cnt.
interface uart_tx_queue_if #(
  parameter int unsigned AW = 4
);
  import uart_pkg::*;

  logic                   wr_en;
  logic [UART_DATA_W-1:0] wr_data;
  logic                   flush;
  logic                   full;
  logic                   empty;
  logic [AW:0]            level;
  logic                   ovf;
  logic                   tran_start;
  logic [UART_DATA_W-1:0] trans_data;
  logic                   tx_busy;
  logic                   q_busy;
`ifdef UART_TXQ_OVF_CNT_EN
  logic [7:0]             ovf_cnt;

  modport master (
    output wr_en, wr_data, flush, tx_busy,
    input  full, empty, level, ovf, tran_start, trans_data, q_busy, ovf_cnt
  );
  modport slave (
    input  wr_en, wr_data, flush, tx_busy,
    output full, empty, level, ovf, tran_start, trans_data, q_busy, ovf_cnt
  );
`else
  modport master (
    output wr_en, wr_data, flush, tx_busy,
    input  full, empty, level, ovf, tran_start, trans_data, q_busy
  );
  modport slave (
    input  wr_en, wr_data, flush, tx_busy,
    output full, empty, level, ovf, tran_start, trans_data, q_busy
  );
`endif

endinterface

// File: rtl/uart_fifo_ram.sv
// Byte storage for the transmit queue: one write port, asynchronous read.
// Storage is deliberately unreset; occupancy tracking lives in the parent.
module uart_fifo_ram
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH = TXQ_DEPTH_DEF,
  parameter int unsigned AW    = 4
) (
  input  logic                   clk,
  input  logic                   we_i,
  input  logic [AW-1:0]          waddr_i,
  input  logic [UART_DATA_W-1:0] wdata_i,
  input  logic [AW-1:0]          raddr_i,
  output logic [UART_DATA_W-1:0] rdata_c_o
);

  logic [UART_DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_c_o = mem_q[raddr_i];

endmodule

// File: rtl/uart_tx_queue.sv
// Byte FIFO plus launch FSM feeding the UART transmitter, paced on tx_busy.
// Optional feature macro: UART_TXQ_OVF_CNT_EN (saturating dropped-byte counter).
module uart_tx_queue
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH   = TXQ_DEPTH_DEF,
  parameter int unsigned AW      = 4,
  parameter int unsigned BUSY_TO = TXQ_BUSY_TO_DEF
) (
  input logic             clk,
  input logic             rst,
  uart_tx_queue_if.slave  bus
);

  localparam int unsigned PW = AW + 1;
  localparam int unsigned TW = $clog2(BUSY_TO + 1);
  localparam int unsigned DW = UART_DATA_W;

  localparam logic [1:0] S_IDLE      = 2'(IDLE);
  localparam logic [1:0] S_LAUNCH    = 2'(LAUNCH);
  localparam logic [1:0] S_WAIT_BUSY = 2'(WAIT_BUSY);
  localparam logic [1:0] S_WAIT_DONE = 2'(WAIT_DONE);

  logic [1:0]    state_q, state_d;
  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic [PW-1:0] level_q, level_d;
  logic          full_q, full_d;
  logic          empty_q, empty_d;
  logic          ovf_q, ovf_d;
  logic          tran_start_q, tran_start_d;
  logic [DW-1:0] trans_data_q, trans_data_d;
  logic          q_busy_q, q_busy_d;
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic          push, pop;
  logic [DW-1:0] rd_data;

  uart_fifo_ram #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk       (clk),
    .we_i      (push),
    .waddr_i   (wptr_q[AW-1:0]),
    .wdata_i   (bus.wr_data),
    .raddr_i   (rptr_q[AW-1:0]),
    .rdata_c_o (rd_data)
  );

  // Next-state: flush dominates; full is the registered value, so a pop never frees room for a same-cycle push.
  always_comb begin
    state_d      = state_q;
    wptr_d       = wptr_q;
    rptr_d       = rptr_q;
    trans_data_d = trans_data_q;
    to_cnt_d     = to_cnt_q;
    push         = 1'b0;
    pop          = 1'b0;
    ovf_d        = 1'b0;
    tran_start_d = 1'b0;

    if (bus.flush) begin
      wptr_d   = '0;
      rptr_d   = '0;
      state_d  = S_IDLE;
      to_cnt_d = '0;
    end else begin
      push         = bus.wr_en && !full_q;
      ovf_d        = bus.wr_en && full_q;
      tran_start_d = (state_q == S_LAUNCH);

      case (state_q)
        S_IDLE: begin
          if (!empty_q && !bus.tx_busy) begin
            pop          = 1'b1;
            trans_data_d = rd_data;
            state_d      = S_LAUNCH;
          end
        end
        S_LAUNCH: begin
          state_d  = S_WAIT_BUSY;
          to_cnt_d = '0;
        end
        S_WAIT_BUSY: begin
          // A transmitter that never acknowledges must not wedge the queue.
          if (bus.tx_busy) begin
            state_d = S_WAIT_DONE;
          end else if (to_cnt_q == TW'(BUSY_TO - 1)) begin
            state_d = S_IDLE;
          end else begin
            to_cnt_d = to_cnt_q + TW'(1);
          end
        end
        S_WAIT_DONE: begin
          if (!bus.tx_busy) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase

      if (push) wptr_d = wptr_q + PW'(1);
      if (pop)  rptr_d = rptr_q + PW'(1);
    end

    // Extra pointer MSB distinguishes full from empty when the low bits match.
    level_d  = wptr_d - rptr_d;
    empty_d  = (wptr_d == rptr_d);
    full_d   = (wptr_d[AW] != rptr_d[AW]) && (wptr_d[AW-1:0] == rptr_d[AW-1:0]);
    q_busy_d = (state_d != S_IDLE) || !empty_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      wptr_q       <= '0;
      rptr_q       <= '0;
      level_q      <= '0;
      full_q       <= 1'b0;
      empty_q      <= 1'b1;
      ovf_q        <= 1'b0;
      tran_start_q <= 1'b0;
      trans_data_q <= '0;
      q_busy_q     <= 1'b0;
      to_cnt_q     <= '0;
    end else begin
      state_q      <= state_d;
      wptr_q       <= wptr_d;
      rptr_q       <= rptr_d;
      level_q      <= level_d;
      full_q       <= full_d;
      empty_q      <= empty_d;
      ovf_q        <= ovf_d;
      tran_start_q <= tran_start_d;
      trans_data_q <= trans_data_d;
      q_busy_q     <= q_busy_d;
      to_cnt_q     <= to_cnt_d;
    end
  end

  assign bus.full       = full_q;
  assign bus.empty      = empty_q;
  assign bus.level      = level_q;
  assign bus.ovf        = ovf_q;
  assign bus.tran_start = tran_start_q;
  assign bus.trans_data = trans_data_q;
  assign bus.q_busy     = q_busy_q;

`ifdef UART_TXQ_OVF_CNT_EN
  logic [7:0] ovf_cnt_q, ovf_cnt_d;

  // Dropped-byte counter sticks at 8'hFF.
  always_comb begin
    ovf_cnt_d = ovf_cnt_q;
    if (bus.flush) begin
      ovf_cnt_d = '0;
    end else if (ovf_d && (ovf_cnt_q != 8'hFF)) begin
      ovf_cnt_d = ovf_cnt_q + 8'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) ovf_cnt_q <= '0;
    else      ovf_cnt_q <= ovf_cnt_d;
  end

  assign bus.ovf_cnt = ovf_cnt_q;
`endif

endmodule

// File: tb/tb_uart_tx_queue.sv
// Self-checking bench for uart_tx_queue: queue-based reference model, directed scenarios, random traffic.
module tb_uart_tx_queue;

  localparam int unsigned DEPTH   = 16;
  localparam int unsigned AW      = 4;
  localparam int unsigned BUSY_TO = 64;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  uart_tx_queue_if #(.AW(AW)) bus ();

  uart_tx_queue #(
    .DEPTH   (DEPTH),
    .AW      (AW),
    .BUSY_TO (BUSY_TO)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  // Reference model: byte queue plus "frame in flight" bookkeeping.
  logic [7:0] mq[$];
  int         since;      // edges since the byte left the queue, -1 when no frame in flight
  bit         saw_busy;
  logic [7:0] m_data;
  bit         m_ovf, m_ts;
  int         m_ovfcnt;

  // Transmitter model and launch log.
  int         tx_mode;    // 0 normal frame, 1 stuck busy, 2 never busy
  int         tx_left;
  int         frame_len;
  logic [7:0] launched[$];
  int         ts_cyc[$];

  task automatic chk(input string nm, input logic [31:0] act, input int exp);
    checks++;
    if (act !== 32'(exp)) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    since    = -1;
    saw_busy = 1'b0;
    m_data   = 8'h00;
    m_ovf    = 1'b0;
    m_ts     = 1'b0;
    m_ovfcnt = 0;
  endtask

  task automatic model_edge();
    bit was_full;
    if (bus.flush) begin
      mq.delete();
      since    = -1;
      saw_busy = 1'b0;
      m_ovf    = 1'b0;
      m_ts     = 1'b0;
      m_ovfcnt = 0;
    end else begin
      was_full = (mq.size() == DEPTH);
      if (since >= 0) begin
        since++;
        if (since >= 2) begin
          if (!saw_busy) begin
            if (bus.tx_busy) saw_busy = 1'b1;
            else if (since == BUSY_TO + 1) since = -1;
          end else if (!bus.tx_busy) begin
            since = -1;
          end
        end
      end else if (mq.size() > 0 && !bus.tx_busy) begin
        m_data   = mq.pop_front();
        since    = 0;
        saw_busy = 1'b0;
      end
      m_ts = (since == 1);
      if (bus.wr_en && !was_full) mq.push_back(bus.wr_data);
      m_ovf = bus.wr_en && was_full;
      if (m_ovf && m_ovfcnt < 255) m_ovfcnt++;
    end
  endtask

  task automatic compare();
    chk("level",      32'(bus.level),      mq.size());
    chk("full",       32'(bus.full),       int'(mq.size() == DEPTH));
    chk("empty",      32'(bus.empty),      int'(mq.size() == 0));
    chk("ovf",        32'(bus.ovf),        int'(m_ovf));
    chk("tran_start", 32'(bus.tran_start), int'(m_ts));
    chk("trans_data", 32'(bus.trans_data), int'(m_data));
    chk("q_busy",     32'(bus.q_busy),     int'(since >= 0 || mq.size() > 0));
`ifdef UART_TXQ_OVF_CNT_EN
    chk("ovf_cnt",    32'(bus.ovf_cnt),    m_ovfcnt);
`endif
    if (bus.tran_start === 1'b1) begin
      launched.push_back(bus.trans_data);
      ts_cyc.push_back(cyc);
    end
  endtask

  task automatic tx_update(input logic ts);
    case (tx_mode)
      1:       bus.tx_busy = 1'b1;
      2:       bus.tx_busy = 1'b0;
      default: begin
        if (ts) begin
          bus.tx_busy = 1'b1;
          tx_left     = frame_len;
        end else if (tx_left > 0) begin
          tx_left--;
          if (tx_left == 0) bus.tx_busy = 1'b0;
        end
      end
    endcase
  endtask

  // One clock: model advances on the edge, DUT checked 1 ns later, transmitter reacts at negedge.
  task automatic cycle();
    logic ts;
    @(posedge clk);
    cyc++;
    model_edge();
    #1;
    compare();
    ts = bus.tran_start;
    @(negedge clk);
    tx_update(ts);
  endtask

  task automatic set_tx(input int mode);
    tx_mode = mode;
    tx_left = 0;
    bus.tx_busy = (mode == 1);
  endtask

  task automatic wait_idle(input string nm, input int budget);
    int n = 0;
    while ((bus.q_busy || bus.tx_busy) && n < budget) begin
      cycle();
      n++;
    end
    if (n >= budget) chk({nm, "_idle_timeout"}, 32'(n), 0);
  endtask

  initial begin
    int n0;
    int n;
    rst         = 1'b0;
    bus.wr_en   = 1'b0;
    bus.wr_data = 8'h00;
    bus.flush   = 1'b0;
    bus.tx_busy = 1'b0;
    tx_mode     = 0;
    tx_left     = 0;
    frame_len   = 4;
    model_reset();

    // Reset values
    repeat (2) @(negedge clk);
    chk("rst_level",      32'(bus.level),      0);
    chk("rst_empty",      32'(bus.empty),      1);
    chk("rst_full",       32'(bus.full),       0);
    chk("rst_tran_start", 32'(bus.tran_start), 0);
    chk("rst_trans_data", 32'(bus.trans_data), 0);
    rst = 1'b1;
    cycle();

    // Single byte: tran_start two edges after the push edge
    bus.wr_en = 1'b1; bus.wr_data = 8'hA5;
    cycle();
    chk("t1_level_after_push", 32'(bus.level), 1);
    bus.wr_en = 1'b0;
    cycle();
    chk("t1_level_after_pop", 32'(bus.level), 0);
    chk("t1_no_early_start",  32'(bus.tran_start), 0);
    cycle();
    chk("t1_tran_start", 32'(bus.tran_start), 1);
    chk("t1_trans_data", 32'(bus.trans_data), 32'hA5);
    wait_idle("t1", 200);

    // Fill to full while transmitter busy, then overflow
    launched.delete();
    set_tx(1);
    for (int i = 0; i < 16; i++) begin
      bus.wr_en = 1'b1; bus.wr_data = 8'(i);
      cycle();
    end
    bus.wr_en = 1'b0;
    cycle();
    chk("t2_full",     32'(bus.full),  1);
    chk("t2_level",    32'(bus.level), 16);
    chk("t2_no_start", 32'(launched.size()), 0);
    bus.wr_en = 1'b1; bus.wr_data = 8'hFF;
    cycle();
    bus.wr_en = 1'b0;
    chk("t3_ovf",   32'(bus.ovf),   1);
    chk("t3_level", 32'(bus.level), 16);
`ifdef UART_TXQ_OVF_CNT_EN
    chk("t3_ovf_cnt", 32'(bus.ovf_cnt), 1);
`endif
    cycle();
    chk("t3_ovf_pulse_end", 32'(bus.ovf), 0);
    frame_len = 4;
    set_tx(0);
    wait_idle("t2", 1000);
    chk("t2_launch_count", 32'(launched.size()), 16);
    for (int i = 0; i < 16 && i < launched.size(); i++)
      chk($sformatf("t2_order_%0d", i), 32'(launched[i]), i);

    // Push and pop on the same edge at level 5
    set_tx(1);
    for (int i = 0; i < 5; i++) begin
      bus.wr_en = 1'b1; bus.wr_data = 8'(8'h40 + i);
      cycle();
    end
    chk("t4_level_pre", 32'(bus.level), 5);
    set_tx(0);
    bus.wr_en = 1'b1; bus.wr_data = 8'h55;
    cycle();
    bus.wr_en = 1'b0;
    chk("t4_level_same", 32'(bus.level), 5);
    wait_idle("t4", 1000);

    // Transmitter never acknowledges: timeout then next byte
    set_tx(2);
    ts_cyc.delete();
    bus.wr_en = 1'b1; bus.wr_data = 8'h11;
    cycle();
    bus.wr_data = 8'h22;
    cycle();
    bus.wr_en = 1'b0;
    n = 0;
    while (ts_cyc.size() < 2 && n < 300) begin
      cycle();
      n++;
    end
    chk("t5_two_launches", 32'(ts_cyc.size()), 2);
    if (ts_cyc.size() >= 2) chk("t5_gap", 32'(ts_cyc[1] - ts_cyc[0]), 66);
    wait_idle("t5", 200);

    // Flush with 3 queued while waiting for the frame to finish
    set_tx(0);
    frame_len = 20;
    for (int i = 0; i < 4; i++) begin
      bus.wr_en = 1'b1; bus.wr_data = 8'(8'h60 + i);
      cycle();
    end
    bus.wr_en = 1'b0;
    chk("t6_level_pre",   32'(bus.level),   3);
    chk("t6_tx_busy_pre", 32'(bus.tx_busy), 1);
    bus.flush = 1'b1;
    cycle();
    bus.flush = 1'b0;
    chk("t6_empty",  32'(bus.empty),  1);
    chk("t6_level",  32'(bus.level),  0);
    chk("t6_q_busy", 32'(bus.q_busy), 0);
    chk("t6_data_hold", 32'(bus.trans_data), 32'h60);
    n0 = launched.size();
    repeat (30) cycle();
    chk("t6_no_more_start", 32'(launched.size()), n0);

    // Asynchronous reset while tran_start is high
    set_tx(0);
    frame_len = 10;
    bus.wr_en = 1'b1; bus.wr_data = 8'hA1;
    cycle();
    bus.wr_en = 1'b0;
    cycle();
    @(posedge clk);
    #2;
    chk("t7_ts_pre", 32'(bus.tran_start), 1);
    rst = 1'b0;
    #1;
    chk("t7_level",      32'(bus.level),      0);
    chk("t7_empty",      32'(bus.empty),      1);
    chk("t7_full",       32'(bus.full),       0);
    chk("t7_ovf",        32'(bus.ovf),        0);
    chk("t7_tran_start", 32'(bus.tran_start), 0);
    chk("t7_trans_data", 32'(bus.trans_data), 0);
    chk("t7_q_busy",     32'(bus.q_busy),     0);
`ifdef UART_TXQ_OVF_CNT_EN
    chk("t7_ovf_cnt",    32'(bus.ovf_cnt),    0);
`endif
    model_reset();
    set_tx(0);
    @(negedge clk);
    rst = 1'b1;

    // Random traffic against the model
    for (int blk = 0; blk < 12; blk++) begin
      int r  = int'($urandom_range(0, 9));
      int pw = int'($urandom_range(10, 90));
      frame_len = int'($urandom_range(1, 12));
      set_tx((r < 7) ? 0 : ((r < 9) ? 1 : 2));
      for (int c = 0; c < 250; c++) begin
        bus.wr_en   = (int'($urandom_range(0, 99)) < pw);
        bus.wr_data = 8'($urandom);
        bus.flush   = ($urandom_range(0, 199) == 0);
        cycle();
      end
    end
    bus.wr_en = 1'b0;
    bus.flush = 1'b0;
    set_tx(0);
    wait_idle("rand", 2000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
